// File: rtl/vqueue_sync.sv
// vqueue_sync: single-clock show-ahead FIFO.
// Words flow RAM -> prefetch register -> head register (Q). The RAM is only
// used once head and prefetch are both occupied, and a read is launched
// whenever the prefetch stage has room. As a result, the next word is always
// on hand in the prefetch register or in the RAM output, so Q can advance
// on every pop without a bubble.
module vqueue_sync #(
  parameter int data_width         = 32,
  parameter int addr_width         = 11,
  parameter int almost_empty_level = 1,
  parameter int almost_full_level  = 2**addr_width - 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrEn,
  input  logic [data_width-1:0] Data,
  input  logic                  RdEn,
  output logic [data_width-1:0] Q,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [addr_width:0]   Level,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam logic [addr_width:0] DEPTH = {1'b1, {addr_width{1'b0}}};

  // Backing dual-port RAM. It is not reset.
  logic [data_width-1:0] mem [2**addr_width];
  logic [data_width-1:0] ram_q;
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic [addr_width:0]   ram_cnt;   // words held in RAM and not yet read out
  logic                  rd_pend;   // ram_q carries a word read at the last edge

  // Prefetch stage, which holds the word directly behind the head.
  logic [data_width-1:0] pf_q;
  logic                  pf_vld;

  logic                  head_vld;
  logic                  pop;
  logic                  push;
  logic                  ram_wr;
  logic                  rd_issue;
  logic                  n_head_vld;
  logic [data_width-1:0] n_q;
  logic                  n_pf_vld;
  logic [data_width-1:0] n_pf_q;
  logic [addr_width:0]   n_level;
  logic [addr_width:0]   n_ram_cnt;

  assign head_vld = ~Empty;

  // Next-state of the head and prefetch stages and of the RAM traffic.
  // The oldest word always moves forward first. A new word bypasses the RAM
  // only when nothing older is still waiting there.
  always_comb begin
    pop        = RdEn & head_vld;
    push       = WrEn & (~Full | pop);
    n_head_vld = head_vld;
    n_q        = Q;
    n_pf_vld   = pf_vld;
    n_pf_q     = pf_q;
    ram_wr     = 1'b0;

    if (~head_vld | pop) begin
      if (pf_vld) begin
        n_q        = pf_q;
        n_head_vld = 1'b1;
        n_pf_vld   = 1'b0;
        if (rd_pend) begin
          n_pf_q   = ram_q;
          n_pf_vld = 1'b1;
        end
      end else if (rd_pend) begin
        n_q        = ram_q;
        n_head_vld = 1'b1;
      end else begin
        n_head_vld = 1'b0;  // Q keeps its last value
      end
    end else if (rd_pend) begin
      n_pf_q   = ram_q;
      n_pf_vld = 1'b1;
    end

    if (push) begin
      if (ram_cnt == '0 && !n_head_vld) begin
        n_q        = Data;
        n_head_vld = 1'b1;
      end else if (ram_cnt == '0 && !n_pf_vld) begin
        n_pf_q   = Data;
        n_pf_vld = 1'b1;
      end else begin
        ram_wr = 1'b1;
      end
    end

    // A read is launched only if its data has a free slot when it arrives.
    rd_issue  = (ram_cnt != '0) && !(n_head_vld && n_pf_vld);
    n_ram_cnt = ram_cnt + {{addr_width{1'b0}}, ram_wr} - {{addr_width{1'b0}}, rd_issue};
    n_level   = Level + {{addr_width{1'b0}}, push} - {{addr_width{1'b0}}, pop};
  end

  // RAM write port.
  always_ff @(posedge Clock) begin
    if (ram_wr && !Reset) mem[wr_ptr] <= Data;
  end

  // RAM read port, with 1-cycle registered read.
  always_ff @(posedge Clock) begin
    if (rd_issue && !Reset) ram_q <= mem[rd_ptr];
  end

  // Pipeline state, level counter, registered flags and sticky error bits.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_pend     <= 1'b0;
      pf_vld      <= 1'b0;
      pf_q        <= '0;
      Q           <= '0;
      Empty       <= 1'b1;
      Full        <= 1'b0;
      AlmostEmpty <= (almost_empty_level >= 0);
      AlmostFull  <= (almost_full_level == 0);
      Level       <= '0;
      Overflow    <= 1'b0;
      Underflow   <= 1'b0;
    end else begin
      if (ram_wr)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt     <= n_ram_cnt;
      rd_pend     <= rd_issue;
      pf_vld      <= n_pf_vld;
      pf_q        <= n_pf_q;
      Q           <= n_q;
      Empty       <= ~n_head_vld;
      Full        <= (n_level == DEPTH);
      AlmostEmpty <= (int'(n_level) <= almost_empty_level);
      AlmostFull  <= (int'(n_level) >= almost_full_level);
      Level       <= n_level;
      if (WrEn && Full && !pop) Overflow  <= 1'b1;
      if (RdEn && Empty)        Underflow <= 1'b1;
    end
  end

endmodule

// File: doc/vqueue_sync.md
VQUEUE_SYNC -- requirements
Module: vqueue_sync

Interface
REQ-001 Parameter data_width, default 32, word width in bits.
REQ-002 Parameter addr_width, default 11, storage depth 2**addr_width words.
REQ-003 Parameter almost_empty_level, default 1, AlmostEmpty threshold in words.
REQ-004 Parameter almost_full_level, default 2**addr_width-16, AlmostFull threshold in words.
REQ-005 Clocking and reset SHALL be exactly: one clock; reset is synchronous and active-high.
REQ-006 Clock  input  1  sole clock, all state updates on rising edge.
REQ-007 Reset  input  1  synchronous active-high reset.
REQ-008 WrEn  input  1  write request.
REQ-009 Data  input  data_width  write data.
REQ-010 RdEn  input  1  pop request (acknowledges current Q).
REQ-011 Q  output  data_width  head word, show-ahead (first-word-fall-through).
REQ-012 Empty  output  1  no word presented on Q.
REQ-013 Full  output  1  Level equals 2**addr_width.
REQ-014 AlmostEmpty  output  1  Level <= almost_empty_level.
REQ-015 AlmostFull  output  1  Level >= almost_full_level.
REQ-016 Level  output  addr_width+1  words held, including head word.
REQ-017 Overflow  output  1  sticky, write attempted while Full and no pop.
REQ-018 Underflow  output  1  sticky, RdEn while Empty.

Function
REQ-019 Write accepted when WrEn=1 and (Full=0 or pop accepted in same cycle); accepted words stored in order.
REQ-020 Pop accepted when RdEn=1 and Empty=0; next word (if any) appears on Q the cycle after the pop.
REQ-021 Q valid whenever Empty=0; Q SHALL hold its last value while Empty=1.
REQ-022 Write into empty queue: Empty deasserts and Q shows the word exactly 1 cycle after the write edge.
REQ-023 Simultaneous WrEn and RdEn while Empty=1: write accepted, RdEn ignored, Underflow set.
REQ-024 Simultaneous accepted write and pop: Level unchanged, ordering preserved, including Full and Level=1 cases.
REQ-025 Write while Full without accepted pop: dropped, storage/Level unchanged, Overflow set.
REQ-026 Level increments on accepted write only, decrements on accepted pop only; never wraps beyond 0..2**addr_width.
REQ-027 Read and write pointers addr_width bits, wrap modulo 2**addr_width without gap.
REQ-028 All flags (Empty, Full, AlmostEmpty, AlmostFull) registered, consistent with Level in the same cycle.
REQ-029 Storage uses single-clock dual-port block RAM (1-cycle read) plus head/prefetch register; no combinational path from Data to Q.
REQ-030 Overflow/Underflow cleared only by Reset.

Reset
REQ-031 Reset=1 at rising edge: pointers 0, Level 0, Q 0, Empty 1, Full 0, AlmostEmpty 1, AlmostFull (almost_full_level==0), Overflow 0, Underflow 0.
REQ-032 Reset has priority over simultaneous WrEn/RdEn; in-flight prefetch discarded; RAM contents need not be cleared.
REQ-033 First write accepted on the first edge with Reset=0.

Verification (data_width=8, addr_width=2, almost_empty_level=1, almost_full_level=3)
REQ-034 Reset then write 0x11 -> next cycle Empty=0, Q=0x11, Level=1, AlmostEmpty=1.
REQ-035 Write 0x01..0x04 back-to-back -> Level=4, Full=1, AlmostFull=1; fifth write 0x05 -> dropped, Overflow=1; pops return 0x01,0x02,0x03,0x04 then Empty=1.
REQ-036 Level=4, simultaneous WrEn(0xAA)+RdEn each cycle for 6 cycles -> Level stays 4, Full stays 1, Overflow stays 0, output sequence in order, pointers wrap.
REQ-037 Empty, RdEn=1 with WrEn(0x5A) -> Underflow=1, Level=1 next cycle, Q=0x5A.
REQ-038 Level=3 mid-stream, assert Reset one cycle with WrEn=RdEn=1 -> all outputs at REQ-031 values; subsequent write 0x77 appears on Q 1 cycle later.
REQ-039 Random WrEn/RdEn 10000 cycles against reference queue model -> Q order, Level and all flags match every cycle.
